// File: rtl/clk_div_period_meter.sv
// clk_div_period_meter: selects one tap of a divided-clock bus, synchronises
// it into clk_in, and measures the tap period in clk_in cycles.
// Optional feature macro: PERIOD_CHECK_EN adds err_ratio, which flags a
// measured period that differs from the nominal 2^(sel+1).
module clk_div_period_meter #(
  parameter int unsigned N_TAPS      = 22,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 8388608
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [N_TAPS-1:0] div_bus,
  input  logic [4:0]        sel,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  period,
  output logic              err_timeout,
`ifdef PERIOD_CHECK_EN
  output logic              err_ratio,
`endif
  output logic              err_sel
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_EDGE,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               tmo_q, tmo_d;
  logic               esel_q, esel_d;
  logic               esel_pulse_q, esel_pulse_d;
  logic               sync1_q, sync2_q, dly_q;
  logic               tap_w;
  logic               edge_w;
  logic               sel_ok_w;
  logic [CNT_W-1:0]   cnt_inc_w;
  logic               tmo_hit_w;
`ifdef PERIOD_CHECK_EN
  logic               ratio_q, ratio_d;
  logic [CNT_W-1:0]   nominal_w;
`endif

  // Tap mux driven by the latched select so the synchroniser sees a stable source
  assign tap_w     = div_bus[sel_q];
  assign edge_w    = sync2_q & ~dly_q;
  assign sel_ok_w  = (32'(sel) < N_TAPS);
  assign cnt_inc_w = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign tmo_hit_w = (cnt_q >= CNT_W'(TIMEOUT_CYC));
`ifdef PERIOD_CHECK_EN
  assign nominal_w = CNT_W'(1) << ({1'b0, sel_q} + 6'd1);
`endif

  // Two-flop synchroniser followed by a delay register for rising-edge detection
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= tap_w;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  // Control state, counter and result registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      cnt_q        <= '0;
      period_q     <= '0;
      tmo_q        <= 1'b0;
      esel_q       <= 1'b0;
      esel_pulse_q <= 1'b0;
`ifdef PERIOD_CHECK_EN
      ratio_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      tmo_q        <= tmo_d;
      esel_q       <= esel_d;
      esel_pulse_q <= esel_pulse_d;
`ifdef PERIOD_CHECK_EN
      ratio_q      <= ratio_d;
`endif
    end
  end

  // Next-state logic: accept/reject start, flush, wait for first edge, count to second
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    tmo_d        = tmo_q;
    esel_d       = esel_q;
    esel_pulse_d = 1'b0;
`ifdef PERIOD_CHECK_EN
    ratio_d      = ratio_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (sel_ok_w) begin
            sel_d   = sel;
            tmo_d   = 1'b0;
            esel_d  = 1'b0;
            cnt_d   = '0;
`ifdef PERIOD_CHECK_EN
            ratio_d = 1'b0;
`endif
            state_d = S_ARM;
          end else begin
            // Rejected request: report through the done pulse while staying idle
            esel_d       = 1'b1;
            esel_pulse_d = 1'b1;
          end
        end
      end
      S_ARM, S_WAIT_EDGE, S_MEASURE: begin
        if (tmo_hit_w) begin
          period_d = '0;
          tmo_d    = 1'b1;
          state_d  = S_DONE;
        end else if (state_q == S_ARM) begin
          // cnt runs 0,1,2 here: three cycles flush the synchroniser after the mux change
          cnt_d = cnt_inc_w;
          if (cnt_q == CNT_W'(2)) begin
            state_d = S_WAIT_EDGE;
          end
        end else if (state_q == S_WAIT_EDGE) begin
          if (edge_w) begin
            cnt_d   = CNT_W'(1);
            state_d = S_MEASURE;
          end else begin
            cnt_d = cnt_inc_w;
          end
        end else begin
          if (edge_w) begin
            period_d = cnt_q;
`ifdef PERIOD_CHECK_EN
            ratio_d  = (cnt_q != nominal_w);
`endif
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_inc_w;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q == S_ARM) || (state_q == S_WAIT_EDGE) || (state_q == S_MEASURE);
  assign done        = (state_q == S_DONE) || esel_pulse_q;
  assign period      = period_q;
  assign err_timeout = tmo_q;
  assign err_sel     = esel_q;
`ifdef PERIOD_CHECK_EN
  assign err_ratio   = ratio_q;
`endif

endmodule
